// File: rtl/dm_store_buffer_pkg.sv
// Shared store-type codes and sizing helpers for the data-memory store buffer.
// Code values mirror the codebase's global memory-op include.
package dm_store_buffer_pkg;

    localparam logic [2:0] MEM_NONE = 3'd0;
    localparam logic [2:0] MEM_SW   = 3'd1;
    localparam logic [2:0] MEM_SH   = 3'd2;
    localparam logic [2:0] MEM_SB   = 3'd3;

    function automatic logic is_store(input logic [2:0] t);
        return t != MEM_NONE;
    endfunction

endpackage

// File: rtl/dm_store_buffer_addr_match.sv
// Load/store word-address hazard detector: parallel comparators against all
// valid buffered stores, OR-reduced to a single stall request.
module sb_addr_match #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic [DEPTH-1:0] valid,
    input  logic [AW-1:0]    addr [DEPTH],
    input  logic             ld_valid,
    input  logic [AW-1:0]    ld_addr,
    output logic             ld_hazard
);

    logic [DEPTH-1:0] hit;

    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            hit[i] = valid[i] && (addr[i][AW-1:2] == ld_addr[AW-1:2]);
        end
    end

    assign ld_hazard = ld_valid && (|hit);

endmodule

// File: rtl/dm_store_buffer.sv
// In-order store buffer between execute and data memory; retires one store
// per free memory-port cycle and flags loads that hit a pending store word.
module dm_store_buffer
    import dm_store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    input  logic [2:0]    st_type,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    input  logic [31:0]   st_pc,
    output logic          st_ready,
    input  logic          drain_en,
    output logic [2:0]    dm_write,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_wdata,
    output logic [31:0]   dm_pc,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_hazard,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] ent_valid;

    logic [2:0]       ent_type [DEPTH];
    logic [AW-1:0]    ent_addr [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [31:0]      ent_pc   [DEPTH];

    logic enq;
    logic deq;

    assign empty    = (count == '0);
    assign st_ready = (count != CW'(DEPTH));
    assign enq      = st_valid && is_store(st_type) && st_ready;
    assign deq      = !empty && drain_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (enq && !deq) begin
                count <= count + 1'b1;
            end else if (!enq && deq) begin
                count <= count - 1'b1;
            end
            // enq and deq never target the same slot: that needs count==0 and count==DEPTH at once
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (enq && (wr_ptr == PW'(i))) begin
                    ent_valid[i] <= 1'b1;
                end else if (deq && (rd_ptr == PW'(i))) begin
                    ent_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            ent_type[wr_ptr] <= st_type;
            ent_addr[wr_ptr] <= st_addr;
            ent_data[wr_ptr] <= st_data;
            ent_pc[wr_ptr]   <= st_pc;
        end
    end

    always_comb begin
        dm_write = MEM_NONE;
        if (deq) begin
            dm_write = ent_type[rd_ptr];
        end
    end

    assign dm_addr  = ent_addr[rd_ptr];
    assign dm_wdata = ent_data[rd_ptr];
    assign dm_pc    = ent_pc[rd_ptr];

    sb_addr_match #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_addr_match (
        .valid     (ent_valid),
        .addr      (ent_addr),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_hazard (ld_hazard)
    );

endmodule
